// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the memory arbiter.
//   state_t      : arbiter FSM encoding (IDLE / ISSUE / WAIT)
//   OWN_I/OWN_D  : transaction owner IDs (fetch side / data side)
//   OP_RD/OP_WR  : latched backing-memory operation
//   cnt_width()  : bits needed to hold 0..max
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  function automatic int cnt_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_timer.sv
// arb_timer: clearable saturating up-counter with a terminal-count flag.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : synchronous clear to zero (wins over en)
//   en       : count up by one, holding at MAX
//   tc       : high while the count equals MAX
module arb_timer
  import mem_arbiter_pkg::*;
#(
  parameter int MAX = 31
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int              W   = cnt_width(MAX);
  localparam logic [W-1:0]    LIM = W'(MAX);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LIM)) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == LIM);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported backing memory between the fetch
// stage (reads only) and the memory stage (reads and writes).
//
// Requester handshake: a requester raises its request (i_req, or d_rd/d_wr)
// and holds it, with stable address/data, until it sees its one-cycle done
// pulse. The stall output is the request masked by that pulse, so the
// pipeline advances exactly in the done cycle. Whatever the request lines
// show in the done cycle is arbitrated again, so a requester with nothing
// further to do must drop its request in that cycle.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   i_req/i_addr             fetch read request and address
//   i_rdata/i_done/i_stall   fetch data, done pulse, stall
//   d_rd/d_wr/d_addr/d_wdata data-side request, address, write data
//   d_rdata/d_done/d_stall   load data, done pulse, stall
//   m_rd/m_wr                one-cycle backing command pulses
//   m_addr/m_wdata           latched command address / write data
//   m_busy                   backing memory cannot take a command (IDLE only)
//   m_done/m_rdata           backing completion and read data
//   err                      sticky error (illegal request or timeout)
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 3,
  parameter int TIMEOUT    = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  output logic              i_stall,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_stall,
  output logic              m_rd,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_busy,
  input  logic              m_done,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              err
);

  localparam int           SW         = cnt_width(STARVE_MAX);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  state_t        state;
  state_t        state_nxt;
  logic          own_q;
  logic          op_q;
  logic [SW-1:0] starve_cnt;

  logic d_any;
  logic d_illegal;
  logic grant_i;
  logic grant_d;
  logic timer_clr;
  logic timer_en;
  logic timer_tc;
  logic wait_done;
  logic wait_abort;

  assign d_any     = d_rd | d_wr;
  assign d_illegal = d_rd & d_wr;

  // Arbitration. Data normally wins; fetch wins when data is idle, when the
  // data request is illegal (never granted), or when fetch has been passed
  // over STARVE_MAX times in a row.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if ((state == IDLE) && !m_busy) begin
      if (i_req && ((starve_cnt == STARVE_LIM) || !d_any || d_illegal)) begin
        grant_i = 1'b1;
      end else if (d_any && !d_illegal) begin
        grant_d = 1'b1;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_i || grant_d) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (m_done || timer_tc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    m_rd      = (state == ISSUE) && (op_q == OP_RD);
    m_wr      = (state == ISSUE) && (op_q == OP_WR);
    timer_clr = (state == ISSUE);
    timer_en  = (state == WAIT) && !m_done;
  end

  // m_done outside WAIT is a stale completion and falls through unused.
  assign wait_done  = (state == WAIT) && m_done;
  assign wait_abort = (state == WAIT) && !m_done && timer_tc;

  arb_timer #(
    .MAX (TIMEOUT)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (timer_clr),
    .en  (timer_en),
    .tc  (timer_tc)
  );

  // Winner's command is captured at grant and held through WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      own_q   <= OWN_I;
      op_q    <= OP_RD;
      m_addr  <= '0;
      m_wdata <= '0;
    end else if (grant_d) begin
      own_q   <= OWN_D;
      op_q    <= d_wr ? OP_WR : OP_RD;
      m_addr  <= d_addr;
      m_wdata <= d_wdata;
    end else if (grant_i) begin
      own_q   <= OWN_I;
      op_q    <= OP_RD;
      m_addr  <= i_addr;
    end
  end

  // Completion: read data capture, done pulses, sticky error. An illegal
  // data request still gets a done pulse so the memory stage cannot hang.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_rdata <= '0;
      d_rdata <= '0;
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      err     <= 1'b0;
    end else begin
      i_done <= (wait_done || wait_abort) && (own_q == OWN_I);
      d_done <= ((wait_done || wait_abort) && (own_q == OWN_D))
                || ((state == IDLE) && d_illegal);
      if (wait_done && (own_q == OWN_I)) begin
        i_rdata <= m_rdata;
      end
      if (wait_done && (own_q == OWN_D) && (op_q == OP_RD)) begin
        d_rdata <= m_rdata;
      end
      if (wait_abort && (own_q == OWN_I)) begin
        i_rdata <= '0;
      end
      if (wait_abort && (own_q == OWN_D)) begin
        d_rdata <= '0;
      end
      if (wait_abort || ((state == IDLE) && d_illegal)) begin
        err <= 1'b1;
      end
    end
  end

  // Consecutive data grants taken while fetch was waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!i_req || grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign i_stall = i_req & ~i_done;
  assign d_stall = d_any & ~d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a backing-memory
// responder, a command/data scoreboard and a final report.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int STARVE_MAX = 3;
  localparam int TIMEOUT    = 31;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic              i_req   = 1'b0;
  logic [ADDR_W-1:0] i_addr  = '0;
  logic [DATA_W-1:0] i_rdata;
  logic              i_done;
  logic              i_stall;
  logic              d_rd    = 1'b0;
  logic              d_wr    = 1'b0;
  logic [ADDR_W-1:0] d_addr  = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  logic              d_stall;
  logic              m_rd;
  logic              m_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_busy  = 1'b0;
  logic              m_done  = 1'b0;
  logic [DATA_W-1:0] m_rdata = '0;
  logic              err;

  mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
    .m_rd(m_rd), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_busy(m_busy), .m_done(m_done), .m_rdata(m_rdata), .err(err)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [32:0] exp_cmd_q[$];   // {wr, addr, wdata}
  logic [15:0] exp_i_q[$];
  logic [15:0] exp_d_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic wr, input logic [15:0] addr, input logic [15:0] wdata);
    exp_cmd_q.push_back({wr, addr, wdata});
  endtask

  always @(negedge clk) begin : monitor
    logic [32:0] e;
    if (rst && (m_rd || m_wr)) begin
      check("cmd_expected", 32'(exp_cmd_q.size() != 0), 32'd1);
      if (exp_cmd_q.size() != 0) begin
        e = exp_cmd_q.pop_front();
        check("cmd_op", 32'(m_wr), 32'(e[32]));
        check("cmd_addr", 32'(m_addr), 32'(e[31:16]));
        if (m_wr) check("cmd_wdata", 32'(m_wdata), 32'(e[15:0]));
      end
    end
    if (rst && i_done) begin
      check("i_done_expected", 32'(exp_i_q.size() != 0), 32'd1);
      if (exp_i_q.size() != 0) check("i_rdata", 32'(i_rdata), 32'(exp_i_q.pop_front()));
    end
    if (rst && d_done) begin
      check("d_done_expected", 32'(exp_d_q.size() != 0), 32'd1);
      if (exp_d_q.size() != 0) check("d_rdata", 32'(d_rdata), 32'(exp_d_q.pop_front()));
    end
  end

  // ---------------- backing memory responder ----------------
  logic [15:0] mem [0:255];
  int          lat       = 3;
  bit          no_resp   = 1'b0;
  int          resp_cnt  = 0;
  logic        resp_wr   = 1'b0;
  logic [15:0] resp_addr = '0;
  logic [15:0] resp_wdata = '0;

  always @(negedge clk) begin
    m_done  = 1'b0;
    m_rdata = 16'hDEAD;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        m_done = 1'b1;
        if (resp_wr) mem[resp_addr[7:0]] = resp_wdata;
        else         m_rdata = mem[resp_addr[7:0]];
      end
    end
    if ((m_rd || m_wr) && !no_resp) begin
      resp_cnt   = lat;
      resp_wr    = m_wr;
      resp_addr  = m_addr;
      resp_wdata = m_wdata;
    end
  end

  // ---------------- driver tasks ----------------
  int last_i_done_cyc = 0;
  int last_d_done_cyc = 0;

  task automatic tick();
    @(negedge clk);
  endtask

  // Requesters drop their request in the cycle their done pulse is seen.
  task automatic serve(input int max_cyc);
    int n = 0;
    while ((i_req || d_rd || d_wr) && (n < max_cyc)) begin
      tick();
      n++;
      if (i_done) begin i_req = 1'b0; last_i_done_cyc = cyc; end
      if (d_done) begin d_rd = 1'b0; d_wr = 1'b0; last_d_done_cyc = cyc; end
    end
    check("serve_bound", 32'(i_req || d_rd || d_wr), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    int issue_cyc;
    int ic;
    int dc;
    int n;
    bit saw_mdone;

    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h10] = 16'hBEEF;
    mem[8'h30] = 16'hC0DE;
    mem[8'h40] = 16'h4444;
    mem[8'h50] = 16'h5555;
    mem[8'h70] = 16'h7777;

    // reset values
    repeat (3) tick();
    check("rst_i_rdata", 32'(i_rdata), 32'd0);
    check("rst_d_rdata", 32'(d_rdata), 32'd0);
    check("rst_done", 32'({i_done, d_done}), 32'd0);
    check("rst_cmd", 32'({m_rd, m_wr, m_addr, m_wdata}), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b1;
    tick();

    // 1: fetch only, L=3
    lat = 3;
    tick();
    push_cmd(1'b0, 16'h0010, 16'h0000);
    exp_i_q.push_back(16'hBEEF);
    i_req = 1'b1; i_addr = 16'h0010;
    #1 check("t1_i_stall_c0", 32'(i_stall), 32'd1);
    for (int c = 1; c <= 5; c++) begin
      tick();
      check("t1_m_rd", 32'(m_rd), 32'(c == 1));
      check("t1_i_done", 32'(i_done), 32'(c == 5));
      check("t1_i_stall", 32'(i_stall), 32'(c != 5));
    end
    check("t1_i_rdata", 32'(i_rdata), 32'hBEEF);
    i_req = 1'b0;

    // 2: simultaneous fetch and data write; write goes first
    tick();
    push_cmd(1'b1, 16'h0020, 16'h1234);
    push_cmd(1'b0, 16'h0030, 16'h0000);
    exp_d_q.push_back(16'h0000);
    exp_i_q.push_back(16'hC0DE);
    i_req = 1'b1; i_addr = 16'h0030;
    d_wr = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
    serve(40);
    check("t2_d_before_i", 32'(last_d_done_cyc < last_i_done_cyc), 32'd1);
    check("t2_d_rdata_kept", 32'(d_rdata), 32'd0);

    // 3: back-to-back data reads with fetch held -> D D D I D D D I
    lat = 1;
    tick();
    for (int g = 0; g < 8; g++)
      push_cmd(1'b0, ((g % 4) == 3) ? 16'h0040 : 16'h0020, 16'h0000);
    for (int g = 0; g < 6; g++) exp_d_q.push_back(16'h1234);
    for (int g = 0; g < 2; g++) exp_i_q.push_back(16'h4444);
    d_rd = 1'b1; d_addr = 16'h0020;
    i_req = 1'b1; i_addr = 16'h0040;
    ic = 0; dc = 0; n = 0;
    while ((ic < 2) && (n < 200)) begin
      tick();
      n++;
      if (d_done) dc++;
      if (i_done) begin
        ic++;
        if (ic == 1) check("t3_data_before_fetch", 32'(dc), 32'(STARVE_MAX));
      end
    end
    i_req = 1'b0; d_rd = 1'b0;
    check("t3_fetch_grants", 32'(ic), 32'd2);
    check("t3_data_grants", 32'(dc), 32'd6);

    // 4: m_busy holds off a pending data read
    tick();
    push_cmd(1'b0, 16'h0050, 16'h0000);
    exp_d_q.push_back(16'h5555);
    m_busy = 1'b1; d_rd = 1'b1; d_addr = 16'h0050;
    for (int c = 1; c <= 5; c++) begin
      tick();
      check("t4_no_rd_while_busy", 32'(m_rd), 32'd0);
      check("t4_d_stall", 32'(d_stall), 32'd1);
      if (c == 5) m_busy = 1'b0;
    end
    tick();
    check("t4_rd_after_busy", 32'(m_rd), 32'd1);
    check("t4_d_stall_issue", 32'(d_stall), 32'd1);
    serve(20);

    // 5: no m_done -> timeout abort
    tick();
    no_resp = 1'b1;
    push_cmd(1'b0, 16'h0060, 16'h0000);
    exp_i_q.push_back(16'h0000);
    i_req = 1'b1; i_addr = 16'h0060;
    tick();
    check("t5_issue", 32'(m_rd), 32'd1);
    issue_cyc = cyc;
    tick();
    check("t5_err_before", 32'(err), 32'd0);
    n = 0;
    while (!i_done && (n < 60)) begin
      tick();
      n++;
    end
    check("t5_timeout_cycles", 32'(cyc - issue_cyc), 32'(TIMEOUT + 2));
    check("t5_err_set", 32'(err), 32'd1);
    check("t5_i_rdata_zero", 32'(i_rdata), 32'd0);
    i_req = 1'b0; no_resp = 1'b0;
    tick();
    push_cmd(1'b0, 16'h0020, 16'h0000);
    exp_d_q.push_back(16'h1234);
    d_rd = 1'b1; d_addr = 16'h0020;
    serve(20);
    check("t5_after_d_rdata", 32'(d_rdata), 32'h1234);
    check("t5_err_sticky", 32'(err), 32'd1);

    // 6: reset during WAIT, stale m_done afterwards
    lat = 10;
    tick();
    push_cmd(1'b0, 16'h0070, 16'h0000);
    i_req = 1'b1; i_addr = 16'h0070;
    tick();
    check("t6_issue", 32'(m_rd), 32'd1);
    tick(); tick();
    check("t6_in_wait", 32'(dut.state), 32'(WAIT));
    rst = 1'b0; i_req = 1'b0;
    exp_i_q.delete();
    tick(); tick();
    check("t6_rst_outputs", 32'(|{i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
                                   m_rd, m_wr, m_addr, m_wdata, err}), 32'd0);
    rst = 1'b1;
    saw_mdone = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (m_done) saw_mdone = 1'b1;
      check("t6_quiet", 32'(|{m_rd, m_wr, i_done, d_done, err}), 32'd0);
    end
    check("t6_stale_seen", 32'(saw_mdone), 32'd1);
    check("t6_outputs_zero", 32'(|{i_rdata, d_rdata, m_addr, m_wdata}), 32'd0);
    check("t6_state_idle", 32'(dut.state), 32'(IDLE));

    // 7: d_rd and d_wr together -> error, done pulse, no command
    tick();
    exp_d_q.push_back(16'h0000);
    d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h0080;
    tick();
    check("t7_d_done", 32'(d_done), 32'd1);
    check("t7_err", 32'(err), 32'd1);
    check("t7_no_cmd", 32'(m_rd | m_wr), 32'd0);
    d_rd = 1'b0; d_wr = 1'b0;
    tick();
    check("t7_d_done_once", 32'(d_done), 32'd0);
    check("t7_no_cmd_after", 32'(m_rd | m_wr), 32'd0);

    // final report
    tick();
    check("end_cmd_q_empty", 32'(exp_cmd_q.size()), 32'd0);
    check("end_i_q_empty", 32'(exp_i_q.size()), 32'd0);
    check("end_d_q_empty", 32'(exp_d_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported backing memory between the fetch stage (instruction reads) and the memory stage (data reads/writes) of the 5-stage pipeline.
- Arbitrates between them, sequences each transaction through an issue/wait/complete state machine, and returns data with a done pulse.
- Produces per-requester stall signals, which replace the direct fetch-to-memory and memory-stage-to-memory connections.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- STARVE_MAX, 3, consecutive data-side grants allowed while fetch waits before fetch is forced a grant.
- TIMEOUT, 31, WAIT-state cycles without m_done before the transaction is aborted.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_req  in  1  fetch read request; held until i_done.
- i_addr  in  ADDR_W  fetch address.
- i_rdata  out  DATA_W  fetched word, registered.
- i_done  out  1  one-cycle completion pulse for fetch.
- i_stall  out  1  fetch must stall.
- d_rd  in  1  data read request.
- d_wr  in  1  data write request.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  load data, registered.
- d_done  out  1  one-cycle completion pulse for data.
- d_stall  out  1  memory stage must stall; drives the pipeline-wide stall.
- m_rd  out  1  backing read command, one-cycle pulse.
- m_wr  out  1  backing write command, one-cycle pulse.
- m_addr  out  ADDR_W  latched command address.
- m_wdata  out  DATA_W  latched write data.
- m_busy  in  1  backing memory cannot accept a command.
- m_done  in  1  backing transaction complete; m_rdata valid this cycle.
- m_rdata  in  DATA_W  backing read data.
- err  out  1  sticky error.

Behaviour:
- Reset (rst=0, async): state IDLE; starve_cnt=0; timer=0; all outputs 0, including rdata registers and err.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - Advances only when a legal request is pending and m_busy=0.
  - Winner: data side if d_rd|d_wr; fetch side if only i_req.
  - Fetch wins anyway when i_req=1 and starve_cnt==STARVE_MAX.
  - Winner's addr/wdata/op and owner ID are latched; next state ISSUE.
- ISSUE: m_rd or m_wr=1 for exactly this cycle with the latched address/data; timer cleared; next state WAIT.
- WAIT:
  - On m_done: load m_rdata into the owner's rdata register (reads only; writes leave d_rdata unchanged).
  - Pulse the owner's done next cycle; return to IDLE.
  - A new arbitration may occur in the same cycle the done pulse is high.
- Latency: request seen in cycle N -> m_rd/m_wr in N+1 -> m_done in N+1+L (L≥1) -> done pulse in N+2+L.
- Stalls:
  - i_stall = i_req & ~i_done.
  - d_stall = (d_rd|d_wr) & ~d_done.
  - Both are combinational from registered done pulses.
- Starvation counter:
  - starve_cnt increments when data is granted while i_req=1.
  - Clears when fetch is granted or i_req=0.
  - Saturates at STARVE_MAX.
- Withdrawn request (fetch flushed mid-flight): the transaction still completes and done still pulses; the requester ignores it. No cancel path.
- d_rd & d_wr both 1 in IDLE: err set; the request is not granted; d_done pulses next cycle to avoid deadlock.
- Timeout: timer reaches TIMEOUT in WAIT -> err set, owner's rdata=0, done pulsed, IDLE.
- m_done in IDLE or ISSUE: ignored, no error. This covers stale completions after reset mid-transaction.
- m_busy is sampled only in IDLE. Once issued, the command is not retried.
- err is cleared only by reset.

Decomposition:
- Shared package:
  - state encoding constants (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2).
  - owner IDs (OWN_I=1'b0, OWN_D=1'b1).
  - op codes (OP_RD, OP_WR).
- One sub-module, arb_timer: a clearable saturating counter with enable and terminal-count output, instantiated for the timeout.
- The starvation counter stays inline.

Test Plan:
- Fetch only, backing memory L=3: i_req=1, addr 0x0010, m_rdata=0xBEEF -> m_rd in cycle 1; i_done and i_rdata=0xBEEF in cycle 5; i_stall high cycles 0-4, low in cycle 5.
- Simultaneous i_req and d_wr, addr 0x0020, wdata 0x1234 -> m_wr first with 0x0020/0x1234; d_done precedes i_done; d_rdata unchanged.
- d_rd continuously back-to-back with i_req held, STARVE_MAX=3 -> three data grants, then one fetch grant, then the pattern repeats; fetch is never starved more than 3 grants.
- m_busy=1 for 5 cycles with d_rd pending -> no m_rd until the cycle after m_busy falls; d_stall held throughout.
- m_done never returns -> err=1 after TIMEOUT WAIT cycles; done pulsed with rdata=0; the next request is serviced normally; err stays 1.
- rst asserted during WAIT, then a stale m_done arrives after release -> m_done ignored, err=0, all outputs 0, state IDLE.
